iq_settle_monitor: RTL and testbench

IQ_SETTLE_MONITOR -- requirements
Module: iq_settle_monitor

---
 rtl/iq_settle_monitor_pkg.sv | 28 ++
 rtl/iq_settle_monitor_deinterleave.sv | 55 +++++
 rtl/iq_settle_monitor.sv | 158 +++++++++++++++
 tb/tb_iq_settle_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_settle_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : iq_settle_monitor_pkg                                      |
// | Brief   : Shared DSP types and helpers for IQ stream consumers.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package iq_settle_monitor_pkg;

    localparam int c_ABS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        DONE  = 2'd2
    } mon_state_t;

    // Callers sign-extend a w-bit sample; the most negative code clamps to 2^(w-1)-1.
    function automatic logic [c_ABS_W-1:0] sat_abs(input logic signed [c_ABS_W-1:0] x,
                                                    input int unsigned            w);
        logic [c_ABS_W-1:0] w_mag;
        logic [c_ABS_W-1:0] w_max;
        w_max = (c_ABS_W'(1) << (w - 1)) - c_ABS_W'(1);
        w_mag = x[c_ABS_W-1] ? $unsigned(-x) : $unsigned(x);
        return (w_mag > w_max) ? w_max : w_mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_settle_monitor_deinterleave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : iq_deinterleave                                            |
// | Brief   : Splits an interleaved I/Q stream into registered pairs.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iq_deinterleave #(
    parameter int DW = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 iq,
    input  logic signed [DW-1:0] y,
    output logic signed [DW-1:0] y_i,
    output logic signed [DW-1:0] y_q,
    output logic                 pair_valid,
    output logic                 sync_err
);

    logic signed [DW-1:0] r_pend_i;
    logic                 r_pend_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_i   <= '0;
            r_pend_vld <= 1'b0;
            y_i        <= '0;
            y_q        <= '0;
            pair_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            pair_valid <= 1'b0;
            if (!iq) begin
                r_pend_i   <= y;
                r_pend_vld <= 1'b1;
            end else begin
                r_pend_vld <= 1'b0;
                if (r_pend_vld) begin
                    y_i        <= r_pend_i;
                    y_q        <= y;
                    pair_valid <= 1'b1;
                end
            end
            // A fresh unpaired Q outranks a coincident clear so it is never lost.
            if (iq && !r_pend_vld) begin
                sync_err <= 1'b1;
            end else if (clr) begin
                sync_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_settle_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : iq_settle_monitor                                          |
// | Brief   : Measures settling time of a deinterleaved IQ filter output.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module iq_settle_monitor
    import iq_settle_monitor_pkg::*;
#(
    parameter int DW    = 20,
    parameter int CW    = 16,
    parameter int QUIET = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq,
    input  logic signed [DW-1:0] y,
    input  logic                 start,
    input  logic [17:0]          thresh,
    input  logic [CW-1:0]        timeout,
    output logic signed [DW-1:0] y_i,
    output logic signed [DW-1:0] y_q,
    output logic                 pair_valid,
    output logic                 busy,
    output logic                 settled,
    output logic                 timed_out,
    output logic [CW-1:0]        settle_time,
    output logic [DW-1:0]        peak,
    output logic                 sync_err
);

    localparam int c_QW = $clog2(QUIET + 1);

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;

    mon_state_t      r_state,       w_state_nxt;
    logic [CW-1:0]   r_pair_cnt,    w_pair_cnt_nxt;
    logic [c_QW-1:0] r_quiet,       w_quiet_nxt;
    logic [CW-1:0]   r_settle_time, w_settle_time_nxt;
    logic [DW-1:0]   r_peak,        w_peak_nxt;
    logic            r_settled,     w_settled_nxt;
    logic            r_timed_out,   w_timed_out_nxt;

    logic [DW-1:0]   w_abs_i;
    logic [DW-1:0]   w_abs_q;
    logic [DW-1:0]   w_pair_max;
    logic            w_in_bound;
    logic [CW:0]     w_cnt_inc;

    // Reset asserts immediately, releases two clock edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    iq_deinterleave #(
        .DW (DW)
    ) u_deinterleave (
        .clk        (clk),
        .rst_n      (w_rst_n),
        .clr        (start),
        .iq         (iq),
        .y          (y),
        .y_i        (y_i),
        .y_q        (y_q),
        .pair_valid (pair_valid),
        .sync_err   (sync_err)
    );

    assign w_abs_i    = DW'(sat_abs(c_ABS_W'(y_i), DW));
    assign w_abs_q    = DW'(sat_abs(c_ABS_W'(y_q), DW));
    assign w_pair_max = (w_abs_i > w_abs_q) ? w_abs_i : w_abs_q;
    assign w_in_bound = (c_ABS_W'(w_abs_i) <= c_ABS_W'(thresh)) &&
                        (c_ABS_W'(w_abs_q) <= c_ABS_W'(thresh));
    assign w_cnt_inc  = {1'b0, r_pair_cnt} + {{CW{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt       = r_state;
        w_pair_cnt_nxt    = r_pair_cnt;
        w_quiet_nxt       = r_quiet;
        w_settle_time_nxt = r_settle_time;
        w_peak_nxt        = r_peak;
        w_settled_nxt     = r_settled;
        w_timed_out_nxt   = r_timed_out;

        if (start) begin
            w_state_nxt       = WATCH;
            w_pair_cnt_nxt    = '0;
            w_quiet_nxt       = '0;
            w_settle_time_nxt = '0;
            w_peak_nxt        = '0;
            w_settled_nxt     = 1'b0;
            w_timed_out_nxt   = 1'b0;
        end else if (r_state == WATCH) begin
            if (pair_valid) begin
                if (r_pair_cnt < timeout) begin
                    w_pair_cnt_nxt = w_cnt_inc[CW-1:0];
                end
                if (w_pair_max > r_peak) begin
                    w_peak_nxt = w_pair_max;
                end
                if (w_in_bound) begin
                    if (r_quiet == '0) begin
                        w_settle_time_nxt = r_pair_cnt;
                    end
                    w_quiet_nxt = r_quiet + 1'b1;
                end else begin
                    w_quiet_nxt = '0;
                end
                // Settling is tested first so it wins over a coincident timeout.
                if (w_in_bound && (r_quiet == c_QW'(QUIET - 1))) begin
                    w_settled_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end else if (w_cnt_inc >= {1'b0, timeout}) begin
                    w_timed_out_nxt = 1'b1;
                    w_state_nxt     = DONE;
                end
            end else if (r_pair_cnt >= timeout) begin
                w_timed_out_nxt = 1'b1;
                w_state_nxt     = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= IDLE;
            r_pair_cnt    <= '0;
            r_quiet       <= '0;
            r_settle_time <= '0;
            r_peak        <= '0;
            r_settled     <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pair_cnt    <= w_pair_cnt_nxt;
            r_quiet       <= w_quiet_nxt;
            r_settle_time <= w_settle_time_nxt;
            r_peak        <= w_peak_nxt;
            r_settled     <= w_settled_nxt;
            r_timed_out   <= w_timed_out_nxt;
        end
    end

    assign busy        = (r_state == WATCH);
    assign settled     = r_settled;
    assign timed_out   = r_timed_out;
    assign settle_time = r_settle_time;
    assign peak        = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_iq_settle_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_iq_settle_monitor                                       |
// | Brief   : Directed bench with a behavioural settling model.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_iq_settle_monitor;

    localparam int DW    = 20;
    localparam int CW    = 16;
    localparam int QUIET = 4;
    localparam int c_SAT = 2 ** (DW - 1) - 1;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 iq      = 1'b0;
    logic signed [DW-1:0] y       = '0;
    logic                 start   = 1'b0;
    logic [17:0]          thresh  = 18'd10;
    logic [CW-1:0]        timeout = CW'(100);
    logic signed [DW-1:0] y_i;
    logic signed [DW-1:0] y_q;
    logic                 pair_valid;
    logic                 busy;
    logic                 settled;
    logic                 timed_out;
    logic [CW-1:0]        settle_time;
    logic [DW-1:0]        peak;
    logic                 sync_err;

    int n_cmp  = 0;
    int n_fail = 0;

    iq_settle_monitor #(
        .DW    (DW),
        .CW    (CW),
        .QUIET (QUIET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iq          (iq),
        .y           (y),
        .start       (start),
        .thresh      (thresh),
        .timeout     (timeout),
        .y_i         (y_i),
        .y_q         (y_q),
        .pair_valid  (pair_valid),
        .busy        (busy),
        .settled     (settled),
        .timed_out   (timed_out),
        .settle_time (settle_time),
        .peak        (peak),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pairs since start are kept as a list of in-bound flags,
    // and the outcome is read off the trailing in-bound run of that list.
    int                   sync_cnt      = 0;
    bit                   m_have_pend   = 1'b0;
    logic signed [DW-1:0] m_pend        = '0;
    bit                   m_watch       = 1'b0;
    bit                   inb_q[$];
    logic signed [DW-1:0] e_yi          = '0;
    logic signed [DW-1:0] e_yq          = '0;
    bit                   e_pv          = 1'b0;
    bit                   e_sync_err    = 1'b0;
    bit                   e_settled     = 1'b0;
    bit                   e_timed_out   = 1'b0;
    int                   e_peak        = 0;
    int                   e_settle_time = 0;

    function automatic int mag(input logic signed [DW-1:0] v);
        int x;
        x = int'(v);
        if (x < 0) x = -x;
        if (x > c_SAT) x = c_SAT;
        return x;
    endfunction

    task automatic model_reset();
        sync_cnt      = 0;
        m_have_pend   = 1'b0;
        m_pend        = '0;
        m_watch       = 1'b0;
        inb_q.delete();
        e_yi          = '0;
        e_yq          = '0;
        e_pv          = 1'b0;
        e_sync_err    = 1'b0;
        e_settled     = 1'b0;
        e_timed_out   = 1'b0;
        e_peak        = 0;
        e_settle_time = 0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int a_i, a_q, run, sz;
        if (!rst_n) begin
            model_reset();
        end else if (sync_cnt < 2) begin
            sync_cnt++;
        end else begin
            if (start) begin
                m_watch       = 1'b1;
                inb_q.delete();
                e_settled     = 1'b0;
                e_timed_out   = 1'b0;
                e_peak        = 0;
                e_settle_time = 0;
            end else if (m_watch) begin
                if (e_pv) begin
                    a_i = mag(e_yi);
                    a_q = mag(e_yq);
                    inb_q.push_back((a_i <= int'(thresh)) && (a_q <= int'(thresh)));
                    if (a_i > e_peak) e_peak = a_i;
                    if (a_q > e_peak) e_peak = a_q;
                    sz  = inb_q.size();
                    run = 0;
                    for (int k = sz - 1; k >= 0; k--) begin
                        if (!inb_q[k]) break;
                        run++;
                    end
                    if (run > 0) e_settle_time = sz - run;
                    if (run >= QUIET) begin
                        e_settled = 1'b1;
                        m_watch   = 1'b0;
                    end else if (sz >= int'(timeout)) begin
                        e_timed_out = 1'b1;
                        m_watch     = 1'b0;
                    end
                end else if (inb_q.size() >= int'(timeout)) begin
                    e_timed_out = 1'b1;
                    m_watch     = 1'b0;
                end
            end
            if (start) e_sync_err = 1'b0;
            e_pv = 1'b0;
            if (!iq) begin
                m_pend      = y;
                m_have_pend = 1'b1;
            end else if (m_have_pend) begin
                e_yi        = m_pend;
                e_yq        = y;
                e_pv        = 1'b1;
                m_have_pend = 1'b0;
            end else begin
                e_sync_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("y_i",        64'(y_i),        64'(e_yi));
        check("y_q",        64'(y_q),        64'(e_yq));
        check("pair_valid", 64'(pair_valid), 64'(e_pv));
        check("busy",       64'(busy),       64'(m_watch));
        check("settled",    64'(settled),    64'(e_settled));
        check("timed_out",  64'(timed_out),  64'(e_timed_out));
        check("peak",       64'(peak),       64'(e_peak));
        check("sync_err",   64'(sync_err),   64'(e_sync_err));
        if (e_settled) check("settle_time", 64'(settle_time), 64'(e_settle_time));
    end

    task automatic cyc(input bit q, input int v, input bit s);
        @(negedge clk);
        iq    = q;
        y     = DW'(v);
        start = s;
    endtask

    task automatic send_pair(input int vi, input int vq);
        cyc(1'b0, vi, 1'b0);
        cyc(1'b1, vq, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 0, 1'b0);
    endtask

    initial begin
        idle(3);
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_peak",  64'(peak),      64'(0));
        check("rst_y_i",   64'(y_i),       64'(0));

        // First sequence after release falls inside the synchronizer window.
        @(negedge clk);
        rst_n = 1'b1;
        iq    = 1'b0;
        y     = DW'(5);
        cyc(1'b1, 6, 1'b0);
        cyc(1'b0, 7, 1'b0);
        cyc(1'b1, 8, 1'b0);
        cyc(1'b0, 0, 1'b0);
        check("first_pv",  64'(pair_valid), 64'(1));
        check("first_y_i", 64'(y_i),        64'(7));
        check("first_y_q", 64'(y_q),        64'(8));
        check("first_err", 64'(sync_err),   64'(0));

        // Constant loud stream times out after 100 pairs.
        thresh  = 18'd10;
        timeout = CW'(100);
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 100; n++) send_pair(100, -50);
        idle(3);
        check("loud_timed_out", 64'(timed_out), 64'(1));
        check("loud_settled",   64'(settled),   64'(0));
        check("loud_peak",      64'(peak),      64'(100));
        check("loud_busy",      64'(busy),      64'(0));
        send_pair(200, 0);
        idle(2);
        check("done_peak_hold", 64'(peak), 64'(100));
        check("done_y_i",       64'(y_i),  64'(200));

        // Decaying stream settles on pair 6, quiet run begins at pair 3.
        cyc(1'b0, 0, 1'b1);
        send_pair(100, 100); send_pair(50, 50); send_pair(20, 20); send_pair(8, 8);
        send_pair(4, 4);     send_pair(0, 0);   send_pair(0, 0);
        idle(3);
        check("decay_settled", 64'(settled),     64'(1));
        check("decay_time",    64'(settle_time), 64'(3));
        check("decay_busy",    64'(busy),        64'(0));
        check("decay_peak",    64'(peak),        64'(100));

        // Equal to thresh is in-bound, one above is not.
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 3; n++) send_pair(10, -10);
        send_pair(11, 0);
        for (int n = 0; n < 4; n++) send_pair(10, 10);
        idle(3);
        check("edge_settled", 64'(settled),     64'(1));
        check("edge_time",    64'(settle_time), 64'(4));

        // Most negative sample saturates; settle and timeout coincide on pair 4.
        thresh  = 18'd0;
        timeout = CW'(5);
        cyc(1'b0, 0, 1'b1);
        send_pair(-524288, 0);
        for (int n = 0; n < 4; n++) send_pair(0, 0);
        idle(3);
        check("sat_peak",      64'(peak),        64'(524287));
        check("sat_settled",   64'(settled),     64'(1));
        check("sat_timed_out", 64'(timed_out),   64'(0));
        check("sat_time",      64'(settle_time), 64'(1));

        // Unpaired Q samples.
        thresh  = 18'd10;
        timeout = CW'(100);
        send_pair(1, 2);
        for (int n = 0; n < 3; n++) cyc(1'b1, 7, 1'b0);
        idle(2);
        check("sync_set", 64'(sync_err), 64'(1));
        cyc(1'b0, 0, 1'b1);
        idle(2);
        check("sync_clr", 64'(sync_err), 64'(0));

        // Restart on the cycle pair 5 completes.
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 6; n++) send_pair(50, 50);
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 4; n++) send_pair(3, 3);
        idle(3);
        check("restart_settled", 64'(settled),     64'(1));
        check("restart_time",    64'(settle_time), 64'(0));
        check("restart_peak",    64'(peak),        64'(3));

        // Start landing on the settling pair.
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 4; n++) send_pair(3, 3);
        cyc(1'b0, 0, 1'b1);
        idle(2);
        check("collide_settled", 64'(settled), 64'(0));
        check("collide_busy",    64'(busy),    64'(1));
        for (int n = 0; n < 4; n++) send_pair(0, 0);
        idle(3);
        check("collide_after", 64'(settled), 64'(1));
        check("collide_peak",  64'(peak),    64'(0));

        // Asynchronous reset mid-measurement.
        cyc(1'b0, 0, 1'b1);
        for (int n = 0; n < 3; n++) send_pair(50, 50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy),       64'(0));
        check("arst_peak", 64'(peak),       64'(0));
        check("arst_y_i",  64'(y_i),        64'(0));
        check("arst_pv",   64'(pair_valid), 64'(0));
        check("arst_to",   64'(timed_out),  64'(0));
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;

        // timeout of zero ends the measurement one cycle after start.
        timeout = CW'(0);
        idle(3);
        cyc(1'b0, 0, 1'b1);
        cyc(1'b0, 0, 1'b0);
        check("to0_busy",  64'(busy),      64'(1));
        check("to0_early", 64'(timed_out), 64'(0));
        cyc(1'b0, 0, 1'b0);
        check("to0_timed_out", 64'(timed_out), 64'(1));
        check("to0_done",      64'(busy),      64'(0));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
